// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;

  // sll r0,r0,0 encodes as all zeros
  localparam logic [INST_W-1:0] NOP              = 32'h0000_0000;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } fetch_state_t;

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority select: jar > jump > branch > pending target > pc+4.
// redirect flags a fresh redirect from decode this cycle; next_pc is then its aligned target.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [INST_W-1:0] pc,
  input  logic              pending_valid,
  input  logic [INST_W-1:0] pending_pc,
  input  logic              jar,
  input  logic [INST_W-1:0] jrtarget,
  input  logic              jump,
  input  logic [INST_W-1:0] jumptarget,
  input  logic              branch,
  input  logic [INST_W-1:0] branchtarget,
  output logic [INST_W-1:0] next_pc,
  output logic              redirect
);

  always_comb begin
    redirect = jar | jump | branch;
    if (jar) begin
      next_pc = word_align(jrtarget);
    end else if (jump) begin
      next_pc = word_align(jumptarget);
    end else if (branch) begin
      next_pc = word_align(branchtarget);
    end else if (pending_valid) begin
      next_pc = pending_pc;
    end else begin
      next_pc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and preserves the delay slot.
// Define FETCH_PERF_EN to add the saturating fetch_bubbles counter output.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic [INST_W-1:0] branchtarget,
  input  logic              jump,
  input  logic [INST_W-1:0] jumptarget,
  input  logic              jar,
  input  logic [INST_W-1:0] jrtarget,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] instout,
  output logic [INST_W-1:0] delayout,
  output logic [INST_W-1:0] delay2out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_bubbles
`endif
);

  fetch_state_t      state;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] pending_pc;
  logic              pending_valid;
  logic [INST_W-1:0] hold_word;
  logic [INST_W-1:0] next_pc;
  logic              redirect;
  logic              present;
  logic              deliver;
  logic [INST_W-1:0] word;

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .pending_valid (pending_valid),
    .pending_pc    (pending_pc),
    .jar           (jar),
    .jrtarget      (jrtarget),
    .jump          (jump),
    .jumptarget    (jumptarget),
    .branch        (branch),
    .branchtarget  (branchtarget),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  assign imem_addr = pc;

  // The PC stays on the address of the word being presented until it is delivered.
  always_comb begin
    present = 1'b0;
    word    = NOP;
    if (!reset) begin
      case (state)
        WAIT: begin
          if (imem_ready) begin
            present = 1'b1;
            word    = imem_data;
          end
        end
        HOLD: begin
          present = 1'b1;
          word    = hold_word;
        end
        default: ;
      endcase
    end
  end

  assign deliver   = present & ~stall;
  assign instout   = word;
  assign delayout  = present ? pc + 32'd4 : '0;
  assign delay2out = present ? pc + 32'd8 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      pc            <= RESET_PC;
      pending_pc    <= RESET_PC;
      pending_valid <= 1'b0;
      hold_word     <= NOP;
    end else begin
      case (state)
        IDLE: begin
          state    <= WAIT;
          imem_req <= 1'b1;
        end
        WAIT: begin
          if (imem_ready && stall) begin
            hold_word <= imem_data;
            state     <= HOLD;
            imem_req  <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            state    <= WAIT;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
      // A redirect never cancels the in-flight word: that word is the delay slot.
      if (deliver) begin
        pc            <= next_pc;
        pending_valid <= 1'b0;
      end else if (redirect && !stall) begin
        pending_pc    <= next_pc;
        pending_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_bubbles <= '0;
    end else if (!present && !stall && fetch_bubbles != 32'hFFFF_FFFF) begin
      fetch_bubbles <= fetch_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-programmable memory, address-stream model checked every cycle,
// and directed redirect/stall/reset scenarios with literal expected fetch sequences.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branchtarget = '0;
  logic        jump = 1'b0;
  logic [31:0] jumptarget = '0;
  logic        jar = 1'b0;
  logic [31:0] jrtarget = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instout;
  logic [31:0] delayout;
  logic [31:0] delay2out;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_bubbles;
`endif

  int checks = 0;
  int errors = 0;

  int   lat = 0;
  logic force_ready = 1'b0;
  int   wcnt = 0;

  logic [31:0] dlog[$];

  logic [31:0] m_seq = '0;
  logic [31:0] m_pend = '0;
  logic        m_pend_v = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_idle = 1'b1;
  int unsigned m_bub = 0;
  logic        p_present;
  logic        p_redir;
  logic [31:0] p_tgt;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC_TB)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .branchtarget (branchtarget),
    .jump         (jump),
    .jumptarget   (jumptarget),
    .jar          (jar),
    .jrtarget     (jrtarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .instout      (instout),
    .delayout     (delayout),
    .delay2out    (delay2out)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubbles(fetch_bubbles)
`endif
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory: answers the outstanding request after lat wait cycles (lat=0 answers in the request cycle).
  initial forever begin
    @(negedge clk);
    #1;
    if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ready = 1'b1;
        imem_data  = memword(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ready = force_ready;
        imem_data  = 32'hBAD0_0000;
        wcnt++;
      end
    end else begin
      imem_ready = force_ready;
      imem_data  = 32'hBAD0_0000;
      wcnt       = 0;
    end
  end

  // Model: tracks the architectural address stream and whether a word is parked by a stall.
  initial forever begin
    @(negedge clk);
    #3;
    if (reset) begin
      m_seq    = RESET_PC_TB;
      m_pend_v = 1'b0;
      m_hold   = 1'b0;
      m_idle   = 1'b1;
      m_bub    = 0;
    end else begin
      p_present = !m_idle && (m_hold || imem_ready);
      checkOutput("instout", instout, p_present ? memword(m_seq) : NOP);
      checkOutput("delayout", delayout, p_present ? m_seq + 32'd4 : 32'd0);
      checkOutput("delay2out", delay2out, p_present ? m_seq + 32'd8 : 32'd0);
      checkOutput("imem_req", 32'(imem_req), 32'(!m_idle && !m_hold));
      if (imem_req || m_idle) checkOutput("imem_addr", imem_addr, m_seq);
`ifdef FETCH_PERF_EN
      checkOutput("fetch_bubbles", fetch_bubbles, m_bub);
`endif
      p_redir = !stall && (jar || jump || branch);
      p_tgt   = jar ? jrtarget : (jump ? jumptarget : branchtarget);
      p_tgt[1:0] = 2'b00;
      if (p_present && !stall) begin
        dlog.push_back(delayout - 32'd4);
        m_seq    = p_redir ? p_tgt : (m_pend_v ? m_pend : m_seq + 32'd4);
        m_pend_v = 1'b0;
        m_hold   = 1'b0;
      end else begin
        if (p_present) m_hold = 1'b1;
        if (p_redir) begin
          m_pend   = p_tgt;
          m_pend_v = 1'b1;
        end
      end
      if (!p_present && !stall) m_bub++;
      m_idle = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic r, input logic [31:0] rt);
    stall        = s;
    branch       = b;
    branchtarget = bt;
    jump         = j;
    jumptarget   = jt;
    jar          = r;
    jrtarget     = rt;
  endtask

  task automatic clearStimulus();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic doReset(input int l);
    clearStimulus();
    reset = 1'b1;
    lat   = l;
    tick();
    #3;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RESET_PC_TB);
    checkOutput("rst_inst", instout, NOP);
    checkOutput("rst_delay", delayout, 32'd0);
    checkOutput("rst_delay2", delay2out, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic waitDelivered(input logic [31:0] addr, input int budget, output int idx);
    int n0;
    n0  = dlog.size();
    idx = -1;
    for (int i = 0; i < budget && idx < 0; i++) begin
      tick();
      if (dlog.size() > n0 && dlog[$] == addr) idx = dlog.size() - 1;
    end
    checkOutput("wait_delivery", 32'(idx >= 0), 32'd1);
  endtask

  task automatic checkSeq(input string name, input int idx, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    if (idx >= 0) begin
      if (dlog.size() < idx + 4) begin
        checkOutput({name, "_len"}, 32'(dlog.size()), 32'(idx + 4));
      end else begin
        checkOutput({name, "_0"}, dlog[idx], e0);
        checkOutput({name, "_1"}, dlog[idx+1], e1);
        checkOutput({name, "_2"}, dlog[idx+2], e2);
        checkOutput({name, "_3"}, dlog[idx+3], e3);
      end
    end
  endtask

  initial begin
    int idx;
    int base;

    // Zero-wait memory: one word per cycle from RESET_PC
    doReset(0);
    base = dlog.size();
    repeat (8) tick();
    checkSeq("seq_lat0", base, 32'h0, 32'h4, 32'h8, 32'hC);

    // Two-cycle latency: bubbles in between, no skipped or repeated address
    doReset(2);
    base = dlog.size();
    repeat (14) tick();
    checkSeq("seq_lat2", base, 32'h0, 32'h4, 32'h8, 32'hC);

    // Branch at 0x10 with zero-wait memory
    doReset(0);
    waitDelivered(32'h10, 40, idx);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clearStimulus();
    repeat (6) tick();
    checkSeq("br_lat0", idx, 32'h10, 32'h14, 32'h40, 32'h44);

    // Same branch through the pending path
    doReset(3);
    waitDelivered(32'h10, 60, idx);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clearStimulus();
    repeat (14) tick();
    checkSeq("br_lat3", idx, 32'h10, 32'h14, 32'h40, 32'h44);

    // Second redirect while one is pending replaces it
    doReset(3);
    waitDelivered(32'h10, 60, idx);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 32'h0);
    tick();
    clearStimulus();
    repeat (14) tick();
    checkSeq("pend_over", idx, 32'h10, 32'h14, 32'h60, 32'h64);

    // jar outranks jump and branch
    doReset(1);
    waitDelivered(32'h10, 40, idx);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h80);
    tick();
    clearStimulus();
    repeat (8) tick();
    checkSeq("jar_prio", idx, 32'h10, 32'h14, 32'h80, 32'h84);

    // Jump outranks branch; unaligned target lands on 0xFFFF_FFFC and the PC wraps
    doReset(0);
    waitDelivered(32'h10, 40, idx);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    tick();
    clearStimulus();
    #3;
    checkOutput("wrap_inst", instout, memword(32'hFFFF_FFFC));
    checkOutput("wrap_delay", delayout, 32'h0);
    checkOutput("wrap_delay2", delay2out, 32'h4);
    repeat (6) tick();
    checkSeq("wrap_seq", idx, 32'h10, 32'h14, 32'hFFFF_FFFC, 32'h0);

    // Stall across a ready pulse: word parked in HOLD, redirect during stall ignored
    doReset(1);
    waitDelivered(32'h8, 40, idx);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    #3;
    checkOutput("hold_req", 32'(imem_req), 32'd0);
    checkOutput("hold_inst", instout, memword(32'hC));
    tick();
    clearStimulus();
    repeat (8) tick();
    checkSeq("stall_seq", idx, 32'h8, 32'hC, 32'h10, 32'h14);

    // Reset mid-request, then a stray ready in IDLE
    doReset(3);
    waitDelivered(32'h4, 40, idx);
    tick();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    force_ready = 1'b1;
    base        = dlog.size();
    #3;
    checkOutput("midrst_addr", imem_addr, RESET_PC_TB);
    checkOutput("idle_ready_ignored", instout, NOP);
    tick();
    force_ready = 1'b0;
    repeat (18) tick();
    checkSeq("after_rst", base, 32'h0, 32'h4, 32'h8, 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
